// File: rtl/trng_vn_sampler_pkg.sv
// Shared constants and the von Neumann FSM state type for the TRNG sampler.
package trng_vn_sampler_pkg;

    localparam int BYTE_W     = 8;
    localparam int SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } vn_state_e;

endpackage

// File: rtl/trng_vn_sampler_if.sv
// Valid/ready byte port of the TRNG sampler; master = producer, slave = consumer.
interface trng_vn_sampler_if;
    import trng_vn_sampler_pkg::*;

    logic [BYTE_W-1:0] rnd_byte;
    logic              rnd_valid;
    logic              rnd_ready;

    modport master (output rnd_byte, output rnd_valid, input rnd_ready);
    modport slave  (input rnd_byte, input rnd_valid, output rnd_ready);

endinterface

// File: rtl/trng_vn_sampler_debias.sv
// Entropy synchronizer, sample decimator and von Neumann corrector FSM.
//   state     | meaning
//   ST_IDLE   | sampling disabled, waiting for i_en
//   ST_FIRST  | waiting for strobe to latch first bit of a pair
//   ST_SECOND | waiting for strobe to compare second bit, emit on mismatch
module trng_vn_sampler_debias
    import trng_vn_sampler_pkg::*;
#(
    parameter int DECIM = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_entropy,
    output logic o_strobe,
    output logic o_sample,
    output logic o_bit,
    output logic o_bit_vld
);

    localparam int              CNT_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DECIM - 1);

    logic [SYNC_DEPTH-1:0] r_sync;
    logic [CNT_W-1:0]      r_decim_cnt;
    vn_state_e             r_state;
    vn_state_e             w_state_nxt;
    logic                  r_first;
    logic                  w_latch;
    logic                  w_bit_vld;
    logic                  w_strobe;
    logic                  w_sample;

    assign w_sample = r_sync[SYNC_DEPTH-1];
    assign w_strobe = i_en && (r_decim_cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync      <= '0;
            r_decim_cnt <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], i_entropy};
            if (!i_en)
                r_decim_cnt <= '0;
            else if (r_decim_cnt == '0)
                r_decim_cnt <= RELOAD;
            else
                r_decim_cnt <= r_decim_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch)
                r_first <= w_sample;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_bit_vld   = 1'b0;
        if (!i_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   w_state_nxt = ST_FIRST;
                ST_FIRST: begin
                    if (w_strobe) begin
                        w_latch     = 1'b1;
                        w_state_nxt = ST_SECOND;
                    end
                end
                ST_SECOND: begin
                    if (w_strobe) begin
                        w_bit_vld   = (w_sample != r_first);
                        w_state_nxt = ST_FIRST;
                    end
                end
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign o_strobe  = w_strobe;
    assign o_sample  = w_sample;
    assign o_bit     = r_first;
    assign o_bit_vld = w_bit_vld;

endmodule

// File: rtl/trng_vn_sampler.sv
// TRNG sampler top: byte packing, valid/ready output register, saturating drop counter.
// Optional repetition-count health test is built when TRNG_HEALTH_EN is defined.
module trng_vn_sampler
    import trng_vn_sampler_pkg::*;
#(
    parameter int DECIM     = 4,
    parameter int DROP_W    = 8,
    parameter int RCT_LIMIT = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_entropy_in,
    trng_vn_sampler_if.master  rnd_if,
    output logic [DROP_W-1:0]  o_drop_cnt,
    output logic               o_health_fail
);

    localparam int               BCNT_W   = $clog2(BYTE_W);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(BYTE_W - 1);

    logic              w_strobe;
    logic              w_sample;
    logic              w_bit;
    logic              w_bit_vld;
    logic              w_bit_ok;
    logic              w_byte_done;
    logic              w_xfer;
    logic [BYTE_W-1:0] w_byte_new;

    logic [BYTE_W-1:0] r_shreg;
    logic [BCNT_W-1:0] r_bit_cnt;
    logic [BYTE_W-1:0] r_byte;
    logic              r_valid;
    logic [DROP_W-1:0] r_drop;

    trng_vn_sampler_debias #(.DECIM(DECIM)) u_debias (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_en      (i_en),
        .i_entropy (i_entropy_in),
        .o_strobe  (w_strobe),
        .o_sample  (w_sample),
        .o_bit     (w_bit),
        .o_bit_vld (w_bit_vld)
    );

`ifdef TRNG_HEALTH_EN
    localparam int              RCT_W   = $clog2(RCT_LIMIT + 1);
    localparam logic [RCT_W-1:0] RCT_MAX = RCT_W'(RCT_LIMIT);

    logic [RCT_W-1:0] r_rct_cnt;
    logic [RCT_W-1:0] w_rct_nxt;
    logic             r_rct_last;
    logic             r_health;

    // A count of zero means no sample seen yet since enable, so the first one starts a run.
    always_comb begin
        w_rct_nxt = r_rct_cnt;
        if ((r_rct_cnt == '0) || (w_sample != r_rct_last))
            w_rct_nxt = RCT_W'(1);
        else if (r_rct_cnt != RCT_MAX)
            w_rct_nxt = r_rct_cnt + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rct_cnt  <= '0;
            r_rct_last <= 1'b0;
            r_health   <= 1'b0;
        end else if (!i_en) begin
            r_rct_cnt  <= '0;
            r_rct_last <= 1'b0;
            r_health   <= 1'b0;
        end else if (w_strobe) begin
            r_rct_cnt  <= w_rct_nxt;
            r_rct_last <= w_sample;
            if (w_rct_nxt == RCT_MAX)
                r_health <= 1'b1;
        end
    end

    assign w_bit_ok      = w_bit_vld && !r_health;
    assign o_health_fail = r_health;
`else
    logic w_unused;
    assign w_unused      = ^{w_strobe, w_sample, (RCT_LIMIT != 0)};
    assign w_bit_ok      = w_bit_vld;
    assign o_health_fail = 1'b0;
`endif

    assign w_byte_new  = {r_shreg[BYTE_W-2:0], w_bit};
    assign w_byte_done = w_bit_ok && (r_bit_cnt == LAST_BIT);
    assign w_xfer      = r_valid && rnd_if.rnd_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (!i_en) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (w_bit_ok) begin
            r_shreg   <= w_byte_new;
            r_bit_cnt <= w_byte_done ? '0 : r_bit_cnt + 1'b1;
        end
    end

    // Output register is independent of i_en so a held byte survives a disable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte  <= '0;
            r_valid <= 1'b0;
            r_drop  <= '0;
        end else if (w_byte_done) begin
            if (!r_valid || w_xfer) begin
                r_byte  <= w_byte_new;
                r_valid <= 1'b1;
            end else if (r_drop != '1) begin
                r_drop <= r_drop + 1'b1;
            end
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end

    assign rnd_if.rnd_byte  = r_byte;
    assign rnd_if.rnd_valid = r_valid;
    assign o_drop_cnt       = r_drop;

endmodule

// File: tb/tb_trng_vn_sampler.sv
// Directed bench for trng_vn_sampler (DECIM=1, DROP_W=2 so drop-counter saturation is reachable).
module tb_trng_vn_sampler;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       en      = 1'b0;
    logic       entropy = 1'b0;
    logic [1:0] drop_cnt;
    logic       health_fail;

    int checks     = 0;
    int failures   = 0;
    int n_valid    = 0;
    int n_low      = 0;
    int n_hold_err = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_byte  = 8'h00;
    logic [7:0] seen_byte  = 8'h00;

    trng_vn_sampler_if u_if ();

    trng_vn_sampler #(.DECIM(1), .DROP_W(2), .RCT_LIMIT(32)) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_en          (en),
        .i_entropy_in  (entropy),
        .rnd_if        (u_if.master),
        .o_drop_cnt    (drop_cnt),
        .o_health_fail (health_fail)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock per call: sample outputs at negedge, then drive the next raw bit.
    task automatic step(input logic v);
        @(negedge clk);
        if (prev_valid && u_if.rnd_valid && !u_if.rnd_ready && (u_if.rnd_byte !== prev_byte))
            n_hold_err++;
        if (u_if.rnd_valid) begin
            n_valid++;
            seen_byte = u_if.rnd_byte;
        end else begin
            n_low++;
        end
        prev_valid = u_if.rnd_valid;
        prev_byte  = u_if.rnd_byte;
        entropy    = v;
    endtask

    task automatic push_pair(input logic a, input logic b);
        step(a);
        step(b);
    endtask

    task automatic push_bit(input logic b);
        push_pair(b, !b);
    endtask

    // First pair element is driven while en=0; en rises with the second so pairs align.
    task automatic start_bit(input logic b);
        step(b);
        step(!b);
        en = 1'b1;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit start);
        for (int i = 7; i >= 0; i--) begin
            if (start && i == 7) start_bit(b[i]);
            else                 push_bit(b[i]);
        end
    endtask

    task automatic idle_pairs(input int n);
        repeat (n) push_pair(1'b0, 1'b0);
    endtask

    task automatic stop_en();
        step(1'b0);
        en = 1'b0;
        step(1'b0);
        step(1'b0);
    endtask

    initial begin
        u_if.rnd_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid",  32'(u_if.rnd_valid), 32'd0);
        check("rst_byte",   32'(u_if.rnd_byte),  32'h00);
        check("rst_drop",   32'(drop_cnt),       32'd0);
        check("rst_health", 32'(health_fail),    32'd0);
        rst_n = 1'b1;
        step(1'b0);

        // reset in the middle of a byte
        start_bit(1'b1);
        push_bit(1'b0);
        push_bit(1'b1);
        push_bit(1'b1);
        push_bit(1'b0);
        idle_pairs(1);
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check("midrst_valid", 32'(u_if.rnd_valid), 32'd0);
        check("midrst_drop",  32'(drop_cnt),       32'd0);
        step(1'b0);
        step(1'b0);
        rst_n = 1'b1;
        step(1'b0);

        // pairs 10,01,10,10,01,01,10,01 -> 0xB2, single valid pulse with ready=1
        n_valid = 0;
        push_byte(8'hB2, 1'b1);
        idle_pairs(2);
        check("b2_pulses", 32'(n_valid),   32'd1);
        check("b2_byte",   32'(seen_byte), 32'hB2);
        check("b2_vld_lo", 32'(u_if.rnd_valid), 32'd0);

        // constant ones: nothing emitted
        n_valid = 0;
        repeat (40) push_pair(1'b1, 1'b1);
        check("const_valid", 32'(n_valid),  32'd0);
        check("const_drop",  32'(drop_cnt), 32'd0);
`ifdef TRNG_HEALTH_EN
        check("const_health", 32'(health_fail), 32'd1);
`else
        check("const_health", 32'(health_fail), 32'd0);
`endif
        stop_en();
        check("health_clr", 32'(health_fail), 32'd0);

        // ready low, three bytes: first held, two dropped
        u_if.rnd_ready = 1'b0;
        push_byte(8'h3C, 1'b1);
        push_byte(8'hA5, 1'b0);
        push_byte(8'h0F, 1'b0);
        idle_pairs(2);
        check("full_valid", 32'(u_if.rnd_valid), 32'd1);
        check("full_byte",  32'(u_if.rnd_byte),  32'h3C);
        check("full_drop",  32'(drop_cnt),       32'd2);

        // new byte completes on the transfer cycle
        n_low = 0;
        push_byte(8'h96, 1'b0);
        step(1'b0);
        step(1'b0);
        u_if.rnd_ready = 1'b1;
        step(1'b0);
        u_if.rnd_ready = 1'b0;
        step(1'b0);
        check("bb_valid",  32'(u_if.rnd_valid), 32'd1);
        check("bb_byte",   32'(u_if.rnd_byte),  32'h96);
        check("bb_drop",   32'(drop_cnt),       32'd2);
        check("bb_no_gap", 32'(n_low),          32'd0);

        // en dropped after 3 bits, re-raised; next byte dropped, held byte kept
        push_bit(1'b1);
        push_bit(1'b1);
        push_bit(1'b1);
        idle_pairs(1);
        stop_en();
        push_byte(8'h5A, 1'b1);
        idle_pairs(2);
        check("en_hold_byte", 32'(u_if.rnd_byte), 32'h96);
        check("en_drop",      32'(drop_cnt),      32'd3);
        step(1'b0);
        u_if.rnd_ready = 1'b1;
        step(1'b0);
        u_if.rnd_ready = 1'b0;
        check("consume_vld", 32'(u_if.rnd_valid), 32'd0);
        push_byte(8'h71, 1'b0);
        idle_pairs(2);
        check("fresh_valid", 32'(u_if.rnd_valid), 32'd1);
        check("fresh_byte",  32'(u_if.rnd_byte),  32'h71);

        // drop counter saturates at all-ones
        push_byte(8'hC3, 1'b0);
        idle_pairs(2);
        check("sat_drop",  32'(drop_cnt),      32'd3);
        check("sat_byte",  32'(u_if.rnd_byte), 32'h71);
        check("hold_errs", 32'(n_hold_err),    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
